// File: rtl/noc_pkg.sv
// Shared constants, state type and packet field helper for the NoC round-robin arbiter.
package noc_pkg;

    localparam int PKT_W   = 8;
    localparam int ADDR_W  = 4;
    localparam int N_PORTS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    function automatic logic [ADDR_W-1:0] pkt_addr(input logic [PKT_W-1:0] pkt);
        return pkt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or above ptr, modulo 16.
module rr_pick
    import noc_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [ADDR_W-1:0]  ptr,
    output logic [ADDR_W-1:0]  gnt_idx,
    output logic               gnt_any
);

    logic [ADDR_W-1:0] idx;
    logic              found;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            // 4-bit addition wraps naturally, giving the modulo-16 scan order
            idx = ptr + ADDR_W'(k);
            if (!found && req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
        gnt_any = found;
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// 16:1 round-robin arbiter: grants one requester, forwards its packet with the source tag,
// and drops/counts self-addressed packets.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int WIDTH   = PKT_W,
    parameter int N_PORTS = 16,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_PORTS-1:0]         req_valid,
    input  logic [N_PORTS*WIDTH-1:0]   req_data,
    output logic [N_PORTS-1:0]         req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [ADDR_W-1:0]          out_src,
    input  logic                       out_ready,
    output logic                       drop_pulse,
    output logic [CNT_W-1:0]           fwd_count,
    output logic [CNT_W-1:0]           drop_count
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  pkt_q, pkt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0] gnt_idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  sel_pkt;

    rr_pick u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_pkt = req_data[int'(gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pkt_d        = pkt_q;
        src_d        = src_q;
        drop_pulse_d = 1'b0;
        fwd_cnt_d    = fwd_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                // A grant always coincides with req_valid, so it is also the accept
                if (en && gnt_any) begin
                    req_ready = N_PORTS'(1) << gnt_idx;
                    pkt_d     = sel_pkt;
                    src_d     = gnt_idx;
                    if (pkt_addr(sel_pkt) == gnt_idx) begin
                        drop_pulse_d = 1'b1;
                        drop_cnt_d   = drop_cnt_q + CNT_W'(1);
                        ptr_d        = gnt_idx + ADDR_W'(1);
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
                    ptr_d     = src_q + ADDR_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            pkt_q        <= '0;
            src_q        <= '0;
            drop_pulse_q <= 1'b0;
            fwd_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pkt_q        <= pkt_d;
            src_q        <= src_d;
            drop_pulse_q <= drop_pulse_d;
            fwd_cnt_q    <= fwd_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = (state_q == SEND);
    assign out_data   = pkt_q;
    assign out_src    = src_q;
    assign drop_pulse = drop_pulse_q;
    assign fwd_count  = fwd_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed and randomized checks of noc_rr_arbiter against a cycle-level behavioural model.
module tb_noc_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [15:0]  req_valid;
    logic [127:0] req_data;
    logic [15:0]  req_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [3:0]   out_src;
    logic         out_ready;
    logic         drop_pulse;
    logic [15:0]  fwd_count;
    logic [15:0]  drop_count;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    bit       m_hold;
    bit [7:0] m_pkt;
    int       m_src;
    int       m_ptr;
    int       m_fwd;
    int       m_drop;
    bit       m_dpulse;

    noc_rr_arbiter #(.WIDTH(8), .N_PORTS(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .fwd_count  (fwd_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < 16; k++) begin
            if (req_valid[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_pkt = '0; m_src = 0; m_ptr = 0;
        m_fwd = 0; m_drop = 0; m_dpulse = 0;
    endtask

    // Check outputs at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        int g;
        logic [15:0] exp_rdy;
        bit [7:0] p;
        @(negedge clk);
        g = exp_grant();
        exp_rdy = (!m_hold && en && g >= 0) ? (16'h1 << g) : 16'h0;
        chk("req_ready", req_ready, exp_rdy);
        chk("out_valid", out_valid, m_hold);
        if (m_hold) begin
            chk("out_data", out_data, m_pkt);
            chk("out_src", out_src, m_src);
        end
        chk("drop_pulse", drop_pulse, m_dpulse);
        chk("fwd_count", fwd_count, m_fwd);
        chk("drop_count", drop_count, m_drop);
        @(posedge clk);
        m_dpulse = 0;
        if (m_hold) begin
            if (out_ready) begin
                m_fwd  = (m_fwd + 1) & 16'hFFFF;
                m_ptr  = (m_src + 1) % 16;
                m_hold = 0;
            end
        end else if (en && g >= 0) begin
            p = req_data[g*8 +: 8];
            if (int'(p[3:0]) == g) begin
                m_drop   = (m_drop + 1) & 16'hFFFF;
                m_ptr    = (g + 1) % 16;
                m_dpulse = 1;
            end else begin
                m_hold = 1;
                m_pkt  = p;
                m_src  = g;
            end
        end
        #1;
    endtask

    task automatic load_all_ring();
        for (int i = 0; i < 16; i++) req_data[i*8 +: 8] = {4'(i), 4'((i + 1) % 16)};
        req_valid = 16'hFFFF;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_counts", {fwd_count, drop_count}, 0);
        rst_n = 1'b1;

        // single packet from requester 0
        en = 1'b1; out_ready = 1'b1;
        req_valid = 16'h0001; req_data[7:0] = 8'h5A;
        #1 chk("t1_ready", req_ready, 16'h0001);
        tick();
        req_valid = '0;
        chk("t1_out_data", out_data, 8'h5A);
        chk("t1_out_src", out_src, 0);
        tick();
        chk("t1_fwd", fwd_count, 1);

        // all requesters valid: grants rotate from ptr=1
        load_all_ring();
        for (int n = 0; n < 17; n++) begin
            tick();
            tick();
            chk("t2_order", out_src, (1 + n) % 16);
        end
        chk("t2_fwd", fwd_count, 18);
        req_valid = '0;
        tick();

        // self-addressed packet from requester 3
        req_valid = 16'h0008; req_data[3*8 +: 8] = 8'h73;
        tick();
        req_valid = '0;
        chk("t3_pulse", drop_pulse, 1);
        chk("t3_out_valid", out_valid, 0);
        chk("t3_drop", drop_count, 1);
        tick();
        chk("t3_pulse_end", drop_pulse, 0);
        load_all_ring();
        #1 chk("t3_ptr4", req_ready, 16'h0010);
        tick();
        req_valid = '0;
        tick();

        // hold in SEND with out_ready low and en dropped mid-hold
        out_ready = 1'b0;
        req_valid = 16'h0080; req_data[7*8 +: 8] = 8'h42;
        tick();
        req_valid = '0;
        for (int n = 0; n < 5; n++) begin
            if (n == 2) en = 1'b0;
            tick();
            chk("t4_data", out_data, 8'h42);
            chk("t4_src", out_src, 7);
            chk("t4_ready", req_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("t4_done", out_valid, 0);
        en = 1'b1;
        tick();

        // asynchronous reset in the middle of SEND
        out_ready = 1'b0;
        req_valid = 16'h0200; req_data[9*8 +: 8] = 8'h15;
        tick();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_fwd", fwd_count, 0);
        chk("t5_drop", drop_count, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_out_src", out_src, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_all_ring();
        out_ready = 1'b1;
        #1 chk("t5_ptr0", req_ready, 16'h0001);
        tick();
        req_valid = '0;
        tick();

        // forward counter wrap
        force dut.fwd_cnt_q = 16'hFFFF;
        #1 release dut.fwd_cnt_q;
        m_fwd = 16'hFFFF;
        req_valid = 16'h0001; req_data[7:0] = 8'h35;
        tick();
        req_valid = '0;
        tick();
        chk("t6_wrap", fwd_count, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            req_valid = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                req_data[i*8 +: 8] = 8'($urandom);
                if ($urandom_range(3) == 0) req_data[i*8 +: 4] = 4'(i);
            end
            en = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
